prize_collector: RTL
====================

Name: prize_collector

Overview:
- Consumer side of the prize drawing path.
- Watches per-pixel prize and player drawing requests and detects a player/prize overlap on a regular prize.
- Latches the tile and colour of the first overlap in a frame.
- At the next frame boundary, runs a req/ack handshake with the tile grid to clear that prize, then emits a one-cycle score pulse and bumps a saturating collected counter.

Parameters:
- POINTS_BASE, 10, points per colour step; award = POINTS_BASE*(color+1).
- COOLDOWN_FRAMES, 4, frames after a collection during which overlaps are ignored (range 0..15).
- ACK_TIMEOUT, 1023, max clk cycles to wait for clear_ack (used only with the optional feature).

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- startOfFrame  input  1  one-cycle pulse at frame start
- prizeDrawReq  input  1  prize drawer requests current pixel
- playerDrawReq  input  1  player drawer requests current pixel
- prize_type  input  3  type of tile currently drawn (3'b000 FREE, 3'b001 REGU)
- prize_color  input  2  colour index of tile currently drawn
- tileCol  input  5  grid column of tile currently drawn
- tileRow  input  5  grid row of tile currently drawn
- clear_ack  input  1  grid confirms tile cleared
- clear_req  output  1  request grid to clear tile (FREE)
- clear_col  output  5  column to clear, valid while clear_req
- clear_row  output  5  row to clear, valid while clear_req
- score_valid  output  1  one-cycle award pulse
- score_add  output  8  award value, valid with score_valid
- collected_cnt  output  8  total prizes collected, saturating
- timeout_err  output  1  one-cycle pulse on handshake timeout (only with optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE.
  - All outputs 0.
  - Latched coordinates/colour 0; cooldown and timeout counters 0.
- hit = prizeDrawReq && playerDrawReq && prize_type==3'b001, evaluated combinationally each cycle.
- IDLE:
  - On hit with startOfFrame=0: latch tileCol/tileRow/prize_color and go to ARMED.
  - On hit in the same cycle as startOfFrame: the hit is ignored (frame boundary has priority).
- ARMED:
  - Further hits are ignored; the first overlap of the frame wins.
  - On startOfFrame: go to REPORT; clear_req=1 from the next cycle.
  - clear_col/clear_row drive the latched values and are stable throughout REPORT.
- REPORT:
  - clear_req stays 1 until the cycle clear_ack=1 is sampled.
  - On ack: next cycle clear_req=0, score_valid=1 for exactly one cycle, score_add=POINTS_BASE*(latched_color+1) truncated to 8 bits, collected_cnt+1 (holds at 255).
  - Then go to COOLDOWN with the counter loaded to COOLDOWN_FRAMES.
  - clear_ack outside REPORT is ignored.
  - Hits are ignored in REPORT.
- COOLDOWN:
  - Each startOfFrame decrements the counter.
  - When the counter reaches 0, go to IDLE.
  - With COOLDOWN_FRAMES=0, go directly from REPORT to IDLE.
  - Hits are ignored.
- score_add holds its last value between pulses. collected_cnt never wraps.
- Latency from clear_ack to score_valid: 1 cycle.
- A reset asserted mid-handshake drops clear_req asynchronously; no score is awarded.

Optional Feature:
- Macro PRIZE_COLLECT_TIMEOUT_EN.
- Defined:
  - A 10-bit cycle counter runs in REPORT.
  - If ACK_TIMEOUT cycles elapse without clear_ack: drop clear_req, pulse timeout_err for one cycle, go to IDLE.
  - No score is awarded and collected_cnt is unchanged.
  - An ack sampled on the timeout cycle wins (normal award, no timeout_err).
- Undefined: REPORT waits indefinitely; timeout_err is constant 0 and the counter is absent.

Test Plan:
- Normal collection: hit at col 3/row 2, color 2 in frame N → at frame N+1, clear_req=1 with col 3/row 2. Ack after 5 cycles → one cycle later, score_valid=1, score_add=30, collected_cnt=1.
- Two hits in one frame (col 3 then col 7) → only col 3 is reported; exactly one score pulse.
- Hit coincident with startOfFrame, or hit with prize_type=000 → no ARMED transition and no clear_req.
- Cooldown, COOLDOWN_FRAMES=4: hits in each of the 4 frames after collection are ignored. A hit in the 5th frame is collected; collected_cnt=2.
- Saturation: 260 successive collections → collected_cnt holds at 255. Color 3 with POINTS_BASE=70 → score_add=280 mod 256=24.
- resetN low mid-REPORT → clear_req=0 immediately and all outputs 0. With PRIZE_COLLECT_TIMEOUT_EN and no ack → timeout_err pulses at cycle 1023, state returns to IDLE, collected_cnt unchanged.

Source files
------------

// File: rtl/prize_collector.sv
// Prize collector: detects a player/regular-prize overlap, clears the tile at the next frame and awards points.
// Optional handshake timeout is enabled by defining PRIZE_COLLECT_TIMEOUT_EN.
module prize_collector #(
  parameter int POINTS_BASE     = 10,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int ACK_TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       prizeDrawReq,
  input  logic       playerDrawReq,
  input  logic [2:0] prize_type,
  input  logic [1:0] prize_color,
  input  logic [4:0] tileCol,
  input  logic [4:0] tileRow,
  input  logic       clear_ack,
  output logic       clear_req,
  output logic [4:0] clear_col,
  output logic [4:0] clear_row,
  output logic       score_valid,
  output logic [7:0] score_add,
  output logic [7:0] collected_cnt,
  output logic       timeout_err
);

  localparam logic [2:0] TYPE_REGU = 3'b001;
  localparam logic [3:0] CD_LOAD   = 4'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_REPORT   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_clear_req;
  logic [4:0] r_col;
  logic [4:0] r_row;
  logic [1:0] r_color;
  logic       r_score_valid;
  logic [7:0] r_score_add;
  logic [7:0] r_collected;
  logic [3:0] r_cd_cnt;
  logic       w_hit;

  // Award arithmetic wraps modulo 256 by construction of the 8-bit result.
  function automatic logic [7:0] award(input logic [1:0] color);
    return 8'(POINTS_BASE) * ({6'd0, color} + 8'd1);
  endfunction

  assign w_hit = prizeDrawReq && playerDrawReq && (prize_type == TYPE_REGU);

`ifdef PRIZE_COLLECT_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);
  logic [9:0] r_to_cnt;
  logic       r_timeout_err;
`endif

  // Collection FSM with all outputs registered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_clear_req   <= 1'b0;
      r_col         <= 5'd0;
      r_row         <= 5'd0;
      r_color       <= 2'd0;
      r_score_valid <= 1'b0;
      r_score_add   <= 8'd0;
      r_collected   <= 8'd0;
      r_cd_cnt      <= 4'd0;
`ifdef PRIZE_COLLECT_TIMEOUT_EN
      r_to_cnt      <= 10'd0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_score_valid <= 1'b0;
`ifdef PRIZE_COLLECT_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // A hit on the frame-boundary cycle belongs to no frame and is dropped.
          if (w_hit && !startOfFrame) begin
            r_col   <= tileCol;
            r_row   <= tileRow;
            r_color <= prize_color;
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (startOfFrame) begin
            r_clear_req <= 1'b1;
            r_state     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (clear_ack) begin
            r_clear_req   <= 1'b0;
            r_score_valid <= 1'b1;
            r_score_add   <= award(r_color);
            if (r_collected != 8'hFF) begin
              r_collected <= r_collected + 8'd1;
            end
            r_cd_cnt <= CD_LOAD;
            if (CD_LOAD == 4'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_COOLDOWN;
            end
`ifdef PRIZE_COLLECT_TIMEOUT_EN
            r_to_cnt <= 10'd0;
          end else if (r_to_cnt == TO_LAST) begin
            r_clear_req   <= 1'b0;
            r_timeout_err <= 1'b1;
            r_to_cnt      <= 10'd0;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 10'd1;
`endif
          end
        end
        ST_COOLDOWN: begin
          if (startOfFrame) begin
            if (r_cd_cnt <= 4'd1) begin
              r_cd_cnt <= 4'd0;
              r_state  <= ST_IDLE;
            end else begin
              r_cd_cnt <= r_cd_cnt - 4'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_clear_req <= 1'b0;
        end
      endcase
    end
  end

  assign clear_req     = r_clear_req;
  assign clear_col     = r_col;
  assign clear_row     = r_row;
  assign score_valid   = r_score_valid;
  assign score_add     = r_score_add;
  assign collected_cnt = r_collected;
`ifdef PRIZE_COLLECT_TIMEOUT_EN
  assign timeout_err   = r_timeout_err;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule
